// File: rtl/sig_dump_ctrl_pkg.sv
// Shared types and cell-address helpers for the signature dump controller.
package sig_dump_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, READ, WAIT, SEND, DONE} state_e;

   // Word indices of the test-control cells at the top of data memory.
   function automatic int unsigned cell_start_idx(input int unsigned mem_words);
      return mem_words - 1;
   endfunction

   function automatic int unsigned cell_end_idx(input int unsigned mem_words);
      return mem_words - 2;
   endfunction

   function automatic int unsigned cell_halt_idx(input int unsigned mem_words);
      return mem_words - 3;
   endfunction

endpackage

// File: rtl/sig_dump_ctrl_if.sv
// Copy of the core's data-memory request bus, as seen by the snooper.
interface sig_dump_ctrl_if;
   logic        en;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;

   modport master (output en, we, addr, wdata);
   modport slave  (input  en, we, addr, wdata);
endinterface

// File: rtl/sig_dump_ctrl_cell_snoop.sv
// Latches the start/end/halt cells from snooped data-memory writes.
module sig_cell_snoop
   import sig_dump_pkg::*;
#(
   parameter int unsigned MEM_SIZE_WORDS = 1 << 19
)
(
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          i_arm,
   sig_dump_ctrl_if.slave snoop,
   output logic [31:0]   o_start_q,
   output logic [31:0]   o_end_q,
   output logic [31:0]   o_halt_q
);
   localparam int unsigned AW      = $clog2(MEM_SIZE_WORDS * 4);
   localparam int unsigned START_W = cell_start_idx(MEM_SIZE_WORDS);
   localparam int unsigned END_W   = cell_end_idx(MEM_SIZE_WORDS);
   localparam int unsigned HALT_W  = cell_halt_idx(MEM_SIZE_WORDS);

   logic [AW-3:0] w_word;
   logic          w_wr, w_hit_start, w_hit_end, w_hit_halt;
   logic          w_unused_addr;
   logic [31:0]   r_start, r_end, r_halt;

   // Only the word index inside the memory decodes; upper and byte bits are don't-care.
   assign w_word        = snoop.addr[AW-1:2];
   assign w_unused_addr = ^{snoop.addr[31:AW], snoop.addr[1:0]};
   assign w_wr          = i_arm & snoop.en & (|snoop.we);
   assign w_hit_start   = w_wr && (w_word == START_W[AW-3:0]);
   assign w_hit_end     = w_wr && (w_word == END_W[AW-3:0]);
   assign w_hit_halt    = w_wr && (w_word == HALT_W[AW-3:0]);

   // Byte-lane masked update of whichever cell the write hits.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_start <= '0;
         r_end   <= '0;
         r_halt  <= '0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (w_hit_start && snoop.we[b]) r_start[8*b +: 8] <= snoop.wdata[8*b +: 8];
            if (w_hit_end   && snoop.we[b]) r_end[8*b +: 8]   <= snoop.wdata[8*b +: 8];
            if (w_hit_halt  && snoop.we[b]) r_halt[8*b +: 8]  <= snoop.wdata[8*b +: 8];
         end
      end
   end

   assign o_start_q = r_start;
   assign o_end_q   = r_end;
   assign o_halt_q  = r_halt;
endmodule

// File: rtl/sig_dump_ctrl.sv
// Hardware signature dump: waits for halt, then streams the signature region.
module sig_dump_ctrl
   import sig_dump_pkg::*;
#(
   parameter  int unsigned MEM_SIZE_WORDS = 1 << 19,
   parameter  int unsigned DATA_WIDTH     = 32,
   parameter  int unsigned TIMEOUT        = 1000000,
   localparam int unsigned AW             = $clog2(MEM_SIZE_WORDS * 4)
)
(
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  snoop_en_i,
   input  logic [3:0]            snoop_we_i,
   input  logic [31:0]           snoop_addr_i,
   input  logic [DATA_WIDTH-1:0] snoop_wdata_i,
   output logic                  ram_en_o,
   output logic [AW-3:0]         ram_addr_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i,
   output logic                  sig_valid_o,
   input  logic                  sig_ready_i,
   output logic [DATA_WIDTH-1:0] sig_data_o,
   output logic                  sig_last_o,
   output logic                  done_o,
   output logic                  timeout_o
);
   state_e                r_state;
   logic [31:0]           r_cnt;
   logic [AW-3:0]         r_ptr, r_lim;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid, r_last, r_timeout;
   logic [31:0]           w_start_q, w_end_q, w_halt_q;
   logic [AW-3:0]         w_start_w, w_end_w;
   logic                  w_unused_cells;

   sig_dump_ctrl_if u_snoop_if ();

   assign u_snoop_if.en    = snoop_en_i;
   assign u_snoop_if.we    = snoop_we_i;
   assign u_snoop_if.addr  = snoop_addr_i;
   assign u_snoop_if.wdata = snoop_wdata_i;

   // Cells are only writable while idle so a running dump sees a frozen region.
   sig_cell_snoop #(.MEM_SIZE_WORDS(MEM_SIZE_WORDS)) u_cells (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .i_arm     (r_state == IDLE),
      .snoop     (u_snoop_if),
      .o_start_q (w_start_q),
      .o_end_q   (w_end_q),
      .o_halt_q  (w_halt_q)
   );

   assign w_start_w      = w_start_q[AW-1:2];
   assign w_end_w        = w_end_q[AW-1:2];
   assign w_unused_cells = ^{w_start_q[31:AW], w_start_q[1:0], w_end_q[31:AW], w_end_q[1:0]};

   // Dump sequencer: one word per READ -> WAIT -> SEND round trip.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_ptr     <= '0;
         r_lim     <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt <= r_cnt + 32'd1;
               if (w_halt_q == 32'd1) begin
                  r_state <= LOAD;
               end else if (r_cnt == 32'(TIMEOUT - 1)) begin
                  r_state   <= DONE;
                  r_timeout <= 1'b1;
               end
            end
            LOAD: begin
               r_ptr   <= w_start_w;
               r_lim   <= w_end_w;
               r_state <= (w_start_w >= w_end_w) ? DONE : READ;
            end
            READ: r_state <= WAIT;
            WAIT: begin
               r_data  <= ram_rdata_i;
               r_valid <= 1'b1;
               r_last  <= ((r_ptr + (AW-2)'(1)) == r_lim);
               r_state <= SEND;
            end
            SEND: begin
               if (sig_ready_i) begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  r_ptr   <= r_ptr + (AW-2)'(1);
                  r_state <= r_last ? DONE : READ;
               end
            end
            DONE:    r_state <= DONE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ram_en_o    = (r_state == READ);
   assign ram_addr_o  = r_ptr;
   assign sig_valid_o = r_valid;
   assign sig_data_o  = r_data;
   assign sig_last_o  = r_last;
   assign done_o      = (r_state == DONE);
   assign timeout_o   = r_timeout;
endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Directed bench for sig_dump_ctrl with a 1K-word memory and TIMEOUT=50.
module tb_sig_dump_ctrl;
   localparam int unsigned MEMW = 1024;
   localparam int unsigned TO   = 50;
   localparam int unsigned PW   = 10;
   localparam logic [31:0] ST   = 32'h0000_0FFC;
   localparam logic [31:0] EN   = 32'h0000_0FF8;
   localparam logic [31:0] HL   = 32'h0000_0FF4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          ram_en, sig_valid, sig_ready, sig_last, done, tmo;
   logic [PW-1:0] ram_addr;
   logic [31:0]   ram_rdata, sig_data;
   logic [31:0]   mem [0:MEMW-1];
   logic [31:0]   exp_d [3];

   int            checks = 0, errors = 0;
   logic [31:0]   bdata [$];
   logic          blast [$];
   int            nen, stall_viol;
   logic          prev_stall = 1'b0, prev_last;
   logic [31:0]   prev_data;

   always #5 clk = ~clk;

   sig_dump_ctrl_if snp ();

   sig_dump_ctrl #(.MEM_SIZE_WORDS(MEMW), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .snoop_en_i(snp.en), .snoop_we_i(snp.we), .snoop_addr_i(snp.addr), .snoop_wdata_i(snp.wdata),
      .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_rdata_i(ram_rdata),
      .sig_valid_o(sig_valid), .sig_ready_i(sig_ready), .sig_data_o(sig_data), .sig_last_o(sig_last),
      .done_o(done), .timeout_o(tmo)
   );

   always @(posedge clk) if (ram_en) ram_rdata <= mem[ram_addr];

   // Negedge monitor: handshakes, RAM reads, and stability under stall.
   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (ram_en) nen++;
         if (prev_stall && (!sig_valid || sig_data !== prev_data || sig_last !== prev_last)) stall_viol++;
         if (sig_valid && sig_ready) begin
            bdata.push_back(sig_data);
            blast.push_back(sig_last);
         end
         prev_stall = sig_valid && !sig_ready;
         prev_data  = sig_data;
         prev_last  = sig_last;
      end
   end

   task automatic do_reset(input logic rdy);
      rstn = 1'b0; snp.en = 1'b0; snp.we = '0; snp.addr = '0; snp.wdata = '0; sig_ready = rdy;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      bdata.delete(); blast.delete(); nen = 0; stall_viol = 0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
      snp.en = 1'b1; snp.we = we; snp.addr = a; snp.wdata = d;
      @(posedge clk); #1;
      snp.en = 1'b0; snp.we = '0;
   endtask

   task automatic wait_done(input int max, input bit rnd, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (done) begin ok = 1'b1; break; end
         if (rnd) sig_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_valid(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (sig_valid) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
   endtask

   task automatic check_dump(input string tag);
      checks++; if (bdata.size() !== 3) begin errors++; $display("FAIL %s_beats: got %0d expected 3", tag, bdata.size()); end
      for (int i = 0; i < 3 && i < bdata.size(); i++) begin
         checks++; if (bdata[i] !== exp_d[i]) begin errors++; $display("FAIL %s_data%0d: got %h expected %h", tag, i, bdata[i], exp_d[i]); end
         checks++; if (blast[i] !== (i == 2)) begin errors++; $display("FAIL %s_last%0d: got %b expected %b", tag, i, blast[i], (i == 2)); end
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b expected 1", tag, done); end
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL %s_timeout: got %b expected 0", tag, tmo); end
      checks++; if (nen !== 3) begin errors++; $display("FAIL %s_ramreads: got %0d expected 3", tag, nen); end
   endtask

   task automatic test_reset();
      rstn = 1'b0; sig_ready = 1'b0; #1;
      checks++; if (ram_en !== 1'b0)    begin errors++; $display("FAIL rst_ram_en: got %b expected 0", ram_en); end
      checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", sig_valid); end
      checks++; if (sig_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", sig_data); end
      checks++; if (sig_last !== 1'b0)  begin errors++; $display("FAIL rst_last: got %b expected 0", sig_last); end
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
      checks++; if (tmo !== 1'b0)       begin errors++; $display("FAIL rst_timeout: got %b expected 0", tmo); end
   endtask

   task automatic test_basic();
      bit ok;
      do_reset(1'b1);
      wr(ST, 4'hF, 32'h100); wr(EN, 4'hF, 32'h10C); wr(HL, 4'hF, 32'h1);
      wait_done(60, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_wait: got no done expected done within 60 cycles"); end
      check_dump("basic");
   endtask

   task automatic test_stall();
      bit ok;
      do_reset(1'b0);
      // Upper address bits and byte offset of start must not matter.
      wr(32'h8000_0FFC, 4'hF, 32'h103); wr(EN, 4'hF, 32'h10C); wr(HL, 4'hF, 32'h1);
      wait_done(300, 1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_wait: got no done expected done within 300 cycles"); end
      checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable: got %0d violations expected 0", stall_viol); end
      check_dump("stall");
   endtask

   task automatic test_empty();
      do_reset(1'b1);
      wr(ST, 4'hF, 32'h200); wr(EN, 4'hF, 32'h200); wr(HL, 4'hF, 32'h1);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_done0: got %b expected 0", done); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_done1: got %b expected 0", done); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done2: got %b expected 1", done); end
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL empty_timeout: got %b expected 0", tmo); end
      checks++; if (nen !== 0) begin errors++; $display("FAIL empty_ramreads: got %0d expected 0", nen); end
      checks++; if (bdata.size() !== 0) begin errors++; $display("FAIL empty_beats: got %0d expected 0", bdata.size()); end
   endtask

   task automatic test_byte_lanes();
      do_reset(1'b1);
      wr(HL, 4'hF, 32'hFFFF_FF00);
      wr(HL, 4'b0001, 32'h0000_0001);
      repeat (4) @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL lane_notrig: got done=%b expected 0", done); end
      wr(HL, 4'b1110, 32'h0);
      repeat (2) @(posedge clk); #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL lane_trig: got done=%b expected 1", done); end
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL lane_timeout: got %b expected 0", tmo); end
   endtask

   task automatic test_timeout();
      do_reset(1'b1);
      repeat (TO - 1) @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL tmo_early: got done=%b expected 0 at cycle 49", done); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL tmo_done: got %b expected 1 at cycle 50", done); end
      checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b expected 1", tmo); end
      checks++; if (bdata.size() !== 0) begin errors++; $display("FAIL tmo_beats: got %0d expected 0", bdata.size()); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset(1'b0);
      wr(ST, 4'hF, 32'h100); wr(EN, 4'hF, 32'h10C); wr(HL, 4'hF, 32'h1);
      wait_valid(50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mid_beat1: got no valid expected valid within 50 cycles"); end
      sig_ready = 1'b1; @(posedge clk); #1; sig_ready = 1'b0;
      wait_valid(50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mid_beat2: got no valid expected valid within 50 cycles"); end
      checks++; if (bdata.size() !== 1) begin errors++; $display("FAIL mid_count: got %0d expected 1", bdata.size()); end
      rstn = 1'b0; #1;
      checks++; if ({ram_en, sig_valid, sig_last, done, tmo} !== 5'b0) begin errors++; $display("FAIL mid_rst_strobes: got %b expected 00000", {ram_en, sig_valid, sig_last, done, tmo}); end
      checks++; if (sig_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data: got %h expected 0", sig_data); end
      do_reset(1'b1);
      wr(ST, 4'hF, 32'h100); wr(EN, 4'hF, 32'h10C); wr(HL, 4'hF, 32'h1);
      wait_done(60, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mid_rerun_wait: got no done expected done within 60 cycles"); end
      check_dump("rerun");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < MEMW; i++) mem[i] = 32'hDEAD_0000 | i;
      exp_d[0] = 32'hA5A5_0001; exp_d[1] = 32'hB6B6_0002; exp_d[2] = 32'hC7C7_0003;
      mem[10'h40] = exp_d[0]; mem[10'h41] = exp_d[1]; mem[10'h42] = exp_d[2];
      test_reset();
      test_basic();
      test_stall();
      test_empty();
      test_byte_lanes();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
